dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port 64-bit data memory (MEM_WORDS words, word-addressed) between two requesters.
  - Instruction-fetch port (read-only).
  - Memory-stage port (read/write: rmmovq, pushq, call, mrmovq, popq, ret).
- Sequences each access over a fixed-latency RAM and performs the out-of-range check (address >= MEM_WORDS gives an error, and the RAM is not touched).
- Sits between the fetch/memory stages and the RAM macro. Its error outputs feed the stat logic (ADR).

Parameters:
- MEM_WORDS, 8192, number of 64-bit words in the RAM. Power of two.
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata. Range 1..15.
- STARVE_MAX, 4, maximum consecutive data-port grants while fetch is pending. Range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_req  in  1  memory-stage request; held with fields stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  64  word address (valE or valA, as chosen by the memory stage)
- d_wdata  in  64  write data (valA or valP)
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  64  read data (valM); valid with d_ack
- d_err  out  1  address error; valid with d_ack
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  64  word address
- f_ack  out  1  one-cycle completion pulse
- f_rdata  out  64  read data; valid with f_ack
- f_err  out  1  address error; valid with f_ack
- mem_en  out  1  RAM access strobe, one cycle per access
- mem_we  out  1  RAM write enable; qualified by mem_en
- mem_addr  out  $clog2(MEM_WORDS)  RAM word address
- mem_wdata  out  64  RAM write data
- mem_rdata  in  64  RAM read data, valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset.
- Reset values: state IDLE; all ack, err and mem_en/mem_we outputs 0; d_rdata, f_rdata, mem_addr and mem_wdata 0; starve counter 0; latched grant and request fields 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is present, select a winner and latch its port, we, addr and wdata.
  - If the latched addr >= MEM_WORDS, go to RESP with err=1. No mem_en is issued for that request.
  - Otherwise go to ISSUE.
- ISSUE: mem_en=1; mem_we is the latched we (always 0 for fetch); mem_addr is the low bits of the latched addr; mem_wdata is the latched wdata.
  - MEM_LAT=1: go to RESP.
  - MEM_LAT>1: go to WAIT with counter = MEM_LAT-1.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 1.
- RESP:
  - Pulse the winner's ack for one cycle.
  - Read: rdata = mem_rdata sampled this cycle.
  - Write or error: rdata = 0.
  - err as decided in IDLE.
  - Return to IDLE. The next grant is evaluated in that IDLE cycle, so at most one access is in flight.
- Latency, request seen in IDLE at cycle t:
  - Valid read or write: ack at t+1+MEM_LAT.
  - Error: ack at t+1.
- Outputs of the non-winning port stay 0. rdata/err hold their last value between acks; consumers qualify them with ack.
- Arbitration:
  - Data port has priority over fetch.
  - The starve counter increments on each data grant made while f_req=1.
  - When the counter equals STARVE_MAX and f_req=1, fetch wins regardless of d_req.
  - The counter clears on any fetch grant, and on any data grant made while f_req=0.
- Simultaneous d_req and f_req in IDLE: data wins unless the starvation rule applies.
- Requests dropped before ack are a protocol violation. The latched copy is used, and the access completes and acks anyway.
- Reset during ISSUE, WAIT or RESP: abort, no ack, mem_en=0 from the next cycle. Requesters must re-issue.
- Address check uses the full 64-bit compare (no truncation before the compare). The boundary address MEM_WORDS-1 is legal.

Decomposition:
- Shared package dmem_pkg:
  - State enum (IDLE/ISSUE/WAIT/RESP).
  - Port-id constants PORT_D=0, PORT_F=1.
  - Y86 stat codes AOK=1, HLT=2, ADR=3, INS=4, used by the downstream stat logic on d_err/f_err.
- Sub-module dmem_grant_sel: combinational winner select plus the registered starve counter. Inputs d_req, f_req, grant_fire, grant_port. Outputs grant_port_next.

Test Plan:
- Data read, MEM_LAT=1: RAM word 5 = 0xDEAD; d_req, d_we=0, d_addr=5 at t -> mem_en at t+1 with mem_addr=5; d_ack at t+2 with d_rdata=0xDEAD, d_err=0.
- Data write then fetch read: write 0x1234 to addr 8191 -> d_ack, d_rdata=0; then f_req addr 8191 -> f_ack, f_rdata=0x1234.
- Out of range: d_addr=8192 -> d_ack one cycle after grant, d_err=1, mem_en never asserted; same check with f_addr=0xFFFF_FFFF_FFFF_FFFF -> f_err=1.
- Contention with STARVE_MAX=4: d_req and f_req held high continuously -> grant order D,D,D,D,F,D,D,D,D,F; each ack is a single cycle and only one port acks at a time.
- Latency, MEM_LAT=3: read -> mem_en at t+1, ack at t+4; d_rdata equals mem_rdata sampled at t+4.
- Reset in WAIT: assert reset for one cycle mid-access -> no ack, mem_en=0, state IDLE; a re-issued request then completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_F = 1'b1;

  // Y86 status codes raised downstream from d_err/f_err
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  // Full-width compare so that large addresses never alias into the RAM
  function automatic logic addr_out_of_range(input logic [63:0] addr, input int words);
    return addr >= 64'(words);
  endfunction

endpackage

// File: rtl/dmem_grant_sel.sv
// rtl/dmem_grant_sel.sv - data-priority winner select with fetch starvation guard
module dmem_grant_sel
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_req,
  input  logic f_req,
  input  logic grant_fire,
  input  logic grant_port,
  output logic grant_port_next
);

  logic [3:0] starve_cnt;

  always_comb begin
    grant_port_next = PORT_D;
    if (f_req && (!d_req || starve_cnt == 4'(STARVE_MAX))) begin
      grant_port_next = PORT_F;
    end
  end

  // Only data grants that actually held off a waiting fetch count toward starvation
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_fire) begin
      if (grant_port == PORT_F || !f_req) begin
        starve_cnt <= 4'd0;
      end else begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one fixed-latency 64-bit RAM between fetch and memory stages
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS  = 8192,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_ack,
  output logic [63:0]   d_rdata,
  output logic          d_err,
  input  logic          f_req,
  input  logic [63:0]   f_addr,
  output logic          f_ack,
  output logic [63:0]   f_rdata,
  output logic          f_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  state_t        state, state_next;
  logic          lat_port, lat_we, lat_err;
  logic [AW-1:0] lat_addr;
  logic [63:0]   lat_wdata;
  logic [3:0]    wait_cnt;
  logic [63:0]   d_rdata_q, f_rdata_q;
  logic          d_err_q, f_err_q;

  logic          grant_fire, grant_port_next, sel_err;
  logic [63:0]   sel_addr, resp_rdata;

  assign grant_fire = (state == IDLE) && (d_req || f_req);
  assign sel_addr   = (grant_port_next == PORT_F) ? f_addr : d_addr;
  assign sel_err    = addr_out_of_range(sel_addr, MEM_WORDS);

  dmem_grant_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant_sel (
    .clk            (clk),
    .reset          (reset),
    .d_req          (d_req),
    .f_req          (f_req),
    .grant_fire     (grant_fire),
    .grant_port     (grant_port_next),
    .grant_port_next(grant_port_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_port  <= PORT_D;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= 4'd0;
      d_rdata_q <= '0;
      f_rdata_q <= '0;
      d_err_q   <= 1'b0;
      f_err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_fire) begin
        lat_port  <= grant_port_next;
        lat_we    <= (grant_port_next == PORT_D) && d_we;
        lat_err   <= sel_err;
        lat_addr  <= sel_addr[AW-1:0];
        lat_wdata <= (grant_port_next == PORT_D) ? d_wdata : 64'd0;
      end
      if (state == ISSUE) begin
        wait_cnt <= 4'(MEM_LAT - 1);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Hold the last response so rdata/err stay stable between acks
      if (state == RESP) begin
        if (lat_port == PORT_D) begin
          d_rdata_q <= resp_rdata;
          d_err_q   <= lat_err;
        end else begin
          f_rdata_q <= resp_rdata;
          f_err_q   <= lat_err;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_fire) state_next = sel_err ? RESP : ISSUE;
      ISSUE:   state_next = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (wait_cnt <= 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_rdata = (lat_we || lat_err) ? 64'd0 : mem_rdata;
    d_ack      = (state == RESP) && (lat_port == PORT_D);
    f_ack      = (state == RESP) && (lat_port == PORT_F);
    d_rdata    = d_ack ? resp_rdata : d_rdata_q;
    f_rdata    = f_ack ? resp_rdata : f_rdata_q;
    d_err      = d_ack ? lat_err : d_err_q;
    f_err      = f_ack ? lat_err : f_err_q;
    mem_en     = (state == ISSUE);
    mem_we     = (state == ISSUE) && lat_we;
    mem_addr   = lat_addr;
    mem_wdata  = lat_wdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter at MEM_LAT 1 and 3
module tb_dmem_arbiter;

  localparam int MW = 8192;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2];
  logic        d_req [2], d_we [2], f_req [2];
  logic [63:0] d_addr [2], d_wdata [2], f_addr [2];
  logic        d_ack [2], d_err [2], f_ack [2], f_err [2], mem_en [2], mem_we [2];
  logic [63:0] d_rdata [2], f_rdata [2], mem_wdata [2], mem_rdata [2];
  logic [12:0] mem_addr [2];

  int          checks = 0;
  int          errors = 0;
  int          en_cnt [2];
  logic [63:0] ref_mem [int];

  dmem_arbiter #(.MEM_WORDS(MW), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
    .clk(clk), .reset(reset[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0]),
    .f_req(f_req[0]), .f_addr(f_addr[0]),
    .f_ack(f_ack[0]), .f_rdata(f_rdata[0]), .f_err(f_err[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.MEM_WORDS(MW), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
    .clk(clk), .reset(reset[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1]),
    .f_req(f_req[1]), .f_addr(f_addr[1]),
    .f_ack(f_ack[1]), .f_rdata(f_rdata[1]), .f_err(f_err[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // RAM models: read data appears L cycles after mem_en, random junk otherwise
  for (genvar g = 0; g < 2; g++) begin : g_ram
    localparam int L = (g == 0) ? 1 : 3;
    logic [63:0] mem [MW];
    logic [63:0] pipe [L];
    always_ff @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : {$urandom, $urandom};
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[L-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i]) en_cnt[i] <= en_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at the falling edge of an idle cycle; returns at the falling edge of the next idle cycle
  task automatic txn(input int i, input bit port, input bit we, input logic [63:0] addr,
                     input logic [63:0] wdata, input string tag);
    int          lat;
    int          exp_lat;
    int          en0;
    int          key;
    bit          seen;
    bit          exp_err;
    logic [63:0] exp_rd;
    lat     = (i == 0) ? 1 : 3;
    exp_err = (addr >= 64'(MW));
    key     = i * MW + int'(addr[12:0]);
    exp_rd  = 64'd0;
    if (!exp_err && !we && ref_mem.exists(key)) exp_rd = ref_mem[key];
    exp_lat = exp_err ? 1 : 1 + lat;
    en0     = en_cnt[i];
    if (port == 1'b0) begin
      d_req[i] = 1'b1; d_we[i] = we; d_addr[i] = addr; d_wdata[i] = wdata;
    end else begin
      f_req[i] = 1'b1; f_addr[i] = addr;
    end
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (mem_en[i]) begin
        chk({tag, " mem_en cycle"}, 64'(k), 64'd1);
        chk({tag, " mem_addr"}, 64'(mem_addr[i]), 64'(addr[12:0]));
        chk({tag, " mem_we"}, 64'(mem_we[i]), 64'(we));
        if (we) chk({tag, " mem_wdata"}, mem_wdata[i], wdata);
      end
      if (d_ack[i] || f_ack[i]) begin
        seen = 1'b1;
        chk({tag, " latency"}, 64'(k), 64'(exp_lat));
        chk({tag, " d_ack"}, 64'(d_ack[i]), 64'(port == 1'b0));
        chk({tag, " f_ack"}, 64'(f_ack[i]), 64'(port == 1'b1));
        chk({tag, " rdata"}, port ? f_rdata[i] : d_rdata[i], exp_rd);
        chk({tag, " err"}, 64'(port ? f_err[i] : d_err[i]), 64'(exp_err));
        chk({tag, " mem_en count"}, 64'(en_cnt[i] - en0), exp_err ? 64'd0 : 64'd1);
        if (we && !exp_err) ref_mem[key] = wdata;
        d_req[i] = 1'b0; f_req[i] = 1'b0;
      end
    end
    if (!seen) begin
      chk({tag, " ack timeout"}, 64'd0, 64'd1);
      d_req[i] = 1'b0; f_req[i] = 1'b0;
    end
    @(negedge clk);
    chk({tag, " ack single cycle"}, 64'(d_ack[i] | f_ack[i]), 64'd0);
  endtask

  // Both ports held busy: every fifth grant must go to fetch
  task automatic contend(input int i);
    int n;
    bit prev;
    n = 0;
    prev = 1'b0;
    d_req[i] = 1'b1; d_we[i] = 1'b0; d_addr[i] = 64'd10; f_req[i] = 1'b1; f_addr[i] = 64'd11;
    for (int k = 0; k < 300 && n < 10; k++) begin
      @(negedge clk);
      if (d_ack[i] || f_ack[i]) begin
        chk($sformatf("contend%0d one port acks", i), 64'(d_ack[i] & f_ack[i]), 64'd0);
        chk($sformatf("contend%0d ack pulse", i), 64'(prev), 64'd0);
        chk($sformatf("contend%0d grant %0d is fetch", i, n), 64'(f_ack[i]), 64'(n % 5 == 4));
        if (f_ack[i]) chk($sformatf("contend%0d f_rdata", i), f_rdata[i], ref_mem[i*MW+11]);
        else          chk($sformatf("contend%0d d_rdata", i), d_rdata[i], ref_mem[i*MW+10]);
        n++;
        if (n == 10) begin d_req[i] = 1'b0; f_req[i] = 1'b0; end
      end
      prev = d_ack[i] | f_ack[i];
    end
    if (n < 10) begin
      chk($sformatf("contend%0d timeout", i), 64'(n), 64'd10);
      d_req[i] = 1'b0; f_req[i] = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] wd;
    bit          p;
    bit          w;
    int          r;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; d_req[i] = 1'b0; d_we[i] = 1'b0; f_req[i] = 1'b0;
      d_addr[i] = '0; d_wdata[i] = '0; f_addr[i] = '0; en_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset%0d d_ack", i), 64'(d_ack[i]), 64'd0);
      chk($sformatf("reset%0d f_ack", i), 64'(f_ack[i]), 64'd0);
      chk($sformatf("reset%0d d_err", i), 64'(d_err[i]), 64'd0);
      chk($sformatf("reset%0d f_err", i), 64'(f_err[i]), 64'd0);
      chk($sformatf("reset%0d d_rdata", i), d_rdata[i], 64'd0);
      chk($sformatf("reset%0d f_rdata", i), f_rdata[i], 64'd0);
      chk($sformatf("reset%0d mem_en", i), 64'(mem_en[i]), 64'd0);
      chk($sformatf("reset%0d mem_we", i), 64'(mem_we[i]), 64'd0);
      chk($sformatf("reset%0d mem_addr", i), 64'(mem_addr[i]), 64'd0);
      chk($sformatf("reset%0d mem_wdata", i), mem_wdata[i], 64'd0);
      reset[i] = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      txn(i, 1'b0, 1'b1, 64'd5, 64'hDEAD, $sformatf("L%0d wr5", i));
      txn(i, 1'b0, 1'b0, 64'd5, 64'd0, $sformatf("L%0d rd5", i));
      txn(i, 1'b0, 1'b1, 64'd8191, 64'h1234, $sformatf("L%0d wr8191", i));
      txn(i, 1'b1, 1'b0, 64'd8191, 64'd0, $sformatf("L%0d f rd8191", i));
      txn(i, 1'b0, 1'b0, 64'd8192, 64'd0, $sformatf("L%0d d oor rd", i));
      txn(i, 1'b0, 1'b1, 64'd8192, 64'h77, $sformatf("L%0d d oor wr", i));
      txn(i, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, $sformatf("L%0d f oor max", i));
      txn(i, 1'b0, 1'b0, 64'h1_0000_0005, 64'd0, $sformatf("L%0d d oor alias", i));
      for (int a0 = 0; a0 < 16; a0++) begin
        txn(i, 1'b0, 1'b1, 64'(a0), {$urandom, $urandom}, $sformatf("L%0d preload%0d", i, a0));
      end
      contend(i);
      for (int n = 0; n < 40; n++) begin
        r  = $urandom_range(0, 9);
        p  = 1'($urandom_range(0, 1));
        w  = !p && ($urandom_range(0, 1) == 1);
        wd = {$urandom, $urandom};
        if (r == 0)      a = 64'(MW + $urandom_range(0, 1000));
        else if (r == 1) a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        else if (r == 2) a = 64'd8191;
        else             a = 64'($urandom_range(0, 15));
        txn(i, p, w, a, wd, $sformatf("L%0d rnd%0d", i, n));
      end
    end

    // Abort an access in its WAIT phase, then re-issue it
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 64'd10;
    @(negedge clk);
    chk("abort issue mem_en", 64'(mem_en[1]), 64'd1);
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0; d_req[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abort no ack %0d", k), 64'(d_ack[1] | f_ack[1]), 64'd0);
      chk($sformatf("abort no mem_en %0d", k), 64'(mem_en[1]), 64'd0);
      @(negedge clk);
    end
    txn(1, 1'b0, 1'b0, 64'd10, 64'd0, "reissue rd10");
    txn(1, 1'b1, 1'b0, 64'd8191, 64'd0, "reissue f rd8191");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
